vmm_result_uart: RTL and testbench



---
 rtl/vmm_result_uart_pkg.sv | 30 +++
 rtl/vmm_result_uart_if.sv | 13 +
 rtl/vmm_result_uart_tx_byte.sv | 110 +++++++++++
 rtl/vmm_result_uart.sv | 142 ++++++++++++++
 tb/tb_vmm_result_uart.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/vmm_result_uart_pkg.sv
// rtl/vmm_result_uart_pkg.sv - shared constants, state encoding and frame byte builder
package vmm_result_uart_pkg;

    localparam int ENTRY_W     = 10 + 2 * 5;
    localparam int FRAME_BYTES = 3;
    localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

    localparam logic [2:0] BYTE0_MARK = 3'b100;
    localparam logic       BYTE1_MARK = 1'b0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Entry layout is {i[4:0], j[4:0], data[9:0]}.
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                              input logic [1:0]         idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {BYTE0_MARK, entry[19:15]};
            2'd1:    b = {BYTE1_MARK, entry[9:8], entry[14:10]};
            default: b = entry[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vmm_result_uart_if.sv
// rtl/vmm_result_uart_if.sv - result element strobe bus from the matrix-multiply stage
interface vmm_result_uart_if #(
    parameter int DATA_W = 10,
    parameter int IDX_W  = 5
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  res_i;
    logic [IDX_W-1:0]  res_j;

    modport master (output res_valid, output res_data, output res_i, output res_j);
    modport slave  (input  res_valid, input  res_data, input  res_i, input  res_j);
endinterface

// File: rtl/vmm_result_uart_tx_byte.sv
// rtl/vmm_result_uart_tx_byte.sv - 8N1 byte serializer with back-to-back reload at stop completion
module uart_tx_byte
    import vmm_result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       load_i,
    output logic       ready_o,
    output logic       byte_done_o,
    output logic       active_o,
    output logic       tx_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    assign baud_end    = (baud_q == BAUD_LAST);
    assign byte_done_o = (state_q == TX_STOP) && baud_end;
    assign ready_o     = (state_q == TX_IDLE) || byte_done_o;
    assign active_o    = (state_q != TX_IDLE);
    assign tx_o        = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    state_d = TX_START;
                    shreg_d = byte_i;
                    baud_d  = '0;
                end
            end
            TX_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (load_i) begin
                        state_d = TX_START;
                        shreg_d = byte_i;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
        endcase
    end

    // The line is registered from the current state, so it lags the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shreg_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/vmm_result_uart.sv
// rtl/vmm_result_uart.sv - result FIFO and 3-byte frame sequencer feeding the UART serializer
module vmm_result_uart
    import vmm_result_uart_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int IDX_W        = 5,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vmm_result_uart_if.slave      res,
    output logic                  tx_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  fifo_full_o,
    output logic                  overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EW    = DATA_W + 2 * IDX_W;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [ENTRY_W-1:0] frame_q, frame_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic               frame_act_q, frame_act_d;
    logic               frame_end_q, frame_end_d;
    logic               done_q;

    logic [EW-1:0]      entry_w;
    logic [ENTRY_W-1:0] head_w;
    logic               full_w, push_w, pop_w;
    logic               tx_ready, tx_byte_done, tx_active, tx_load;
    logic [7:0]         tx_byte;

    assign entry_w = {res.res_i, res.res_j, res.res_data};
    assign head_w  = mem_q[rd_ptr_q];
    assign full_w  = (count_q == CNT_W'(FIFO_DEPTH));

    // Byte sequencing: finish the current frame first, then pull the next entry.
    always_comb begin
        tx_load     = 1'b0;
        tx_byte     = 8'd0;
        pop_w       = 1'b0;
        frame_d     = frame_q;
        byte_idx_d  = byte_idx_q;
        frame_act_d = frame_act_q;
        if (tx_ready) begin
            if (frame_act_q && (byte_idx_q != LAST_BYTE)) begin
                tx_load    = 1'b1;
                byte_idx_d = byte_idx_q + 2'd1;
                tx_byte    = frame_byte(frame_q, byte_idx_q + 2'd1);
            end else if (count_q != '0) begin
                pop_w       = 1'b1;
                tx_load     = 1'b1;
                frame_d     = head_w;
                byte_idx_d  = 2'd0;
                frame_act_d = 1'b1;
                tx_byte     = frame_byte(head_w, 2'd0);
            end else begin
                frame_act_d = 1'b0;
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        push_w     = res.res_valid && (!full_w || pop_w);
        overflow_d = overflow_q || (res.res_valid && full_w && !pop_w);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_w) begin
            mem_d[wr_ptr_q] = ENTRY_W'(entry_w);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // done_o is delayed twice so it lines up with the end of the last stop bit on tx_o.
    assign frame_end_d = tx_byte_done && frame_act_q && (byte_idx_q == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_q     <= '0;
            byte_idx_q  <= 2'd0;
            frame_act_q <= 1'b0;
            frame_end_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_q     <= frame_d;
            byte_idx_q  <= byte_idx_d;
            frame_act_q <= frame_act_d;
            frame_end_q <= frame_end_d;
            done_q      <= frame_end_q;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .byte_i     (tx_byte),
        .load_i     (tx_load),
        .ready_o    (tx_ready),
        .byte_done_o(tx_byte_done),
        .active_o   (tx_active),
        .tx_o       (tx_o)
    );

    assign done_o      = done_q;
    assign busy_o      = (count_q != '0) || tx_active;
    assign fifo_full_o = full_w;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_vmm_result_uart.sv
// tb/tb_vmm_result_uart.sv - directed scoreboard bench with a UART receive monitor
module tb_vmm_result_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx, done, busy, full, ovf;

    always #5 clk = ~clk;

    vmm_result_uart_if #(.DATA_W(10), .IDX_W(5)) res_if ();

    vmm_result_uart #(
        .DATA_W(10), .IDX_W(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .res(res_if.slave),
        .tx_o(tx), .done_o(done), .busy_o(busy), .fifo_full_o(full), .overflow_o(ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gen = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int last_strobe = 0;
    bit mon_busy = 1'b0;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always begin : rx_mon
        int g;
        logic [7:0] rx;
        logic stb_ok;
        @(negedge clk);
        if (rst === 1'b0 && tx === 1'b0) begin
            mon_busy = 1'b1;
            g = gen;
            start_q.push_back(cyc);
            repeat (2) @(negedge clk);
            stb_ok = (tx === 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                rx[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (g == gen) begin
                check("start_bit", 32'(stb_ok), 1);
                check("stop_bit", 32'(tx), 1);
                if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                else check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
            end
            mon_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic push_frame(input logic [4:0] i, input logic [4:0] j, input logic [9:0] d);
        exp_q.push_back({3'b100, i});
        exp_q.push_back({1'b0, d[9:8], j});
        exp_q.push_back(d[7:0]);
    endtask

    task automatic send(input logic [4:0] i, input logic [4:0] j, input logic [9:0] d, input bit model);
        @(negedge clk);
        res_if.res_valid = 1'b1;
        res_if.res_i     = i;
        res_if.res_j     = j;
        res_if.res_data  = d;
        last_strobe      = cyc;
        if (model) push_frame(i, j, d);
    endtask

    task automatic release_v();
        @(negedge clk);
        res_if.res_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < max), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int s, d0, n;
        rst = 1'b1;
        res_if.res_valid = 1'b0;
        res_if.res_i = '0;
        res_if.res_j = '0;
        res_if.res_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single strobe, literal expected bytes
        start_q.delete();
        d0 = done_cnt;
        send(5'd2, 5'd3, 10'h2A5, 1'b0);
        exp_q.push_back(8'h82); exp_q.push_back(8'h43); exp_q.push_back(8'hA5);
        s = last_strobe;
        release_v();
        check("t1_busy_after_strobe", 32'(busy), 1);
        wait_drain(400);
        check("t1_start_latency", start_q[0], (s + 1) + 2);
        check("t1_nbytes", start_q.size(), 3);
        check("t1_byte_spacing", start_q[2] - start_q[0], 80);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_done_time", last_done_cyc - start_q[0], 120);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_tx_idle", 32'(tx), 1);

        // boundary indices and data
        d0 = done_cnt;
        send(5'd31, 5'd31, 10'h3FF, 1'b0);
        exp_q.push_back(8'h9F); exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
        release_v();
        wait_drain(400);
        check("t6_done_count", done_cnt - d0, 1);

        // five consecutive strobes fill the FIFO exactly
        start_q.delete();
        d0 = done_cnt;
        for (int k = 0; k < 5; k++) send(5'(k + 1), 5'(k + 10), 10'(37 * k + 100), 1'b1);
        release_v();
        check("t2_full", 32'(full), 1);
        check("t2_ovf", 32'(ovf), 0);
        wait_drain(1000);
        check("t2_done_count", done_cnt - d0, 5);
        check("t2_nbytes", start_q.size(), 15);
        check("t2_no_gap", start_q[14] - start_q[0], 14 * 40);

        // push into a full FIFO on the cycle it pops
        start_q.delete();
        d0 = done_cnt;
        send(5'd4, 5'd5, 10'h111, 1'b1);
        s = last_strobe;
        for (int k = 1; k < 5; k++) send(5'(k + 20), 5'(k), 10'(k * 91), 1'b1);
        release_v();
        wait_cyc(s + 120);
        check("t4_full_before_pop", 32'(full), 1);
        send(5'd17, 5'd18, 10'h2C3, 1'b1);
        release_v();
        check("t4_ovf", 32'(ovf), 0);
        wait_drain(1200);
        check("t4_done_count", done_cnt - d0, 6);
        check("t4_no_gap", start_q[17] - start_q[0], 17 * 40);
        check("t4_ovf_end", 32'(ovf), 0);

        // six consecutive strobes: the sixth is dropped
        start_q.delete();
        d0 = done_cnt;
        for (int k = 0; k < 6; k++) send(5'(k + 3), 5'(k + 7), 10'(53 * k + 9), k < 5);
        release_v();
        check("t3_ovf_set", 32'(ovf), 1);
        wait_drain(1000);
        check("t3_done_count", done_cnt - d0, 5);
        check("t3_nbytes", start_q.size(), 15);
        check("t3_ovf_sticky", 32'(ovf), 1);

        // reset in the middle of byte1
        start_q.delete();
        send(5'd7, 5'd9, 10'h155, 1'b1);
        release_v();
        n = 0;
        while (start_q.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_byte1_seen", 32'(start_q.size() >= 2), 1);
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        gen++;
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("t5_rst_tx", 32'(tx), 1);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_full", 32'(full), 0);
        check("t5_rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_tx_idle", 32'(tx), 1);
        send(5'd0, 5'd1, 10'h001, 1'b1);
        release_v();
        wait_drain(400);
        check("t5_fresh_done", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
